// File: rtl/fu_complete_arbiter.sv
// FU-to-complete arbiter: buffers per-FU results and round-robins up to WAYS of them per cycle into the complete stage.
// Macros: BRANCH_PRIORITY_EN grants take_branch heads first; SUPERSCALAR_WAYS sets the default lane count (3).

`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

package fu_complete_arbiter_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 5;
    localparam int unsigned PR_W  = 6;

    typedef struct packed {
        logic             valid;
        logic [ROB_W-1:0] rob_idx;
        logic [PR_W-1:0]  pr_idx;
        logic [XLEN-1:0]  result;
        logic             take_branch;
        logic [XLEN-1:0]  branch_target;
    } fu_complete_packet_t;
endpackage

module fu_complete_arbiter
    import fu_complete_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 6,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned WAYS   = `SUPERSCALAR_WAYS
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              squash_in,
    input  fu_complete_packet_t               fu_result_in    [NUM_FU],
    output logic [NUM_FU-1:0]                 fu_ready_out,
    output fu_complete_packet_t               complete_fu_out [WAYS],
    output logic [$clog2(NUM_FU*DEPTH+1)-1:0] occupancy_out
);
    localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(NUM_FU * DEPTH + 1);
    localparam int unsigned WAY_W = $clog2(WAYS + 1);

    fu_complete_packet_t r_mem   [NUM_FU][DEPTH];
    logic [PTR_W-1:0]    r_head  [NUM_FU];
    logic [PTR_W-1:0]    r_tail  [NUM_FU];
    logic [CNT_W-1:0]    r_count [NUM_FU];
    logic [FU_W-1:0]     r_rr_ptr;
    logic [OCC_W-1:0]    r_occ;

    fu_complete_packet_t w_head [NUM_FU];
    logic [NUM_FU-1:0]   w_push;
    logic [NUM_FU-1:0]   w_grant;
    logic [FU_W-1:0]     w_rr_nxt;
    logic [OCC_W-1:0]    w_n_push;
    logic [OCC_W-1:0]    w_n_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign occupancy_out = r_occ;

    // Ready comes from the registered count only, so a same-cycle pop never frees a slot early.
    always_comb begin : queue_status
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fu_ready_out[i] = r_count[i] < CNT_W'(DEPTH);
            w_head[i]       = r_mem[i][r_head[i]];
            w_push[i]       = fu_result_in[i].valid & fu_ready_out[i] & ~squash_in;
        end
    end

    always_comb begin : select
        logic [WAY_W-1:0] n_grant;
        logic [FU_W-1:0]  idx;
        logic [FU_W-1:0]  last_idx;
        logic             any_rr;
        w_grant  = '0;
        n_grant  = '0;
        idx      = '0;
        last_idx = r_rr_ptr;
        any_rr   = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            complete_fu_out[w] = '0;
        end
`ifdef BRANCH_PRIORITY_EN
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = FU_W'((32'(r_rr_ptr) + k) % NUM_FU);
            if (r_count[idx] != '0 && w_head[idx].take_branch && n_grant < WAY_W'(WAYS)) begin
                complete_fu_out[n_grant]       = w_head[idx];
                complete_fu_out[n_grant].valid = 1'b1;
                w_grant[idx]                   = 1'b1;
                n_grant                        = n_grant + WAY_W'(1);
            end
        end
`endif
        // Normal pass; only its grants move the round-robin pointer.
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            idx = FU_W'((32'(r_rr_ptr) + k) % NUM_FU);
            if (r_count[idx] != '0 && !w_grant[idx] && n_grant < WAY_W'(WAYS)) begin
                complete_fu_out[n_grant]       = w_head[idx];
                complete_fu_out[n_grant].valid = 1'b1;
                w_grant[idx]                   = 1'b1;
                n_grant                        = n_grant + WAY_W'(1);
                last_idx                       = idx;
                any_rr                         = 1'b1;
            end
        end
        if (!any_rr) begin
            w_rr_nxt = r_rr_ptr;
        end else if (last_idx == FU_W'(NUM_FU - 1)) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = last_idx + FU_W'(1);
        end
    end

    always_comb begin : tally
        w_n_push = '0;
        w_n_pop  = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            w_n_push = w_n_push + OCC_W'(w_push[i]);
            w_n_pop  = w_n_pop + OCC_W'(w_grant[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin : state_q
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
            r_rr_ptr <= '0;
            r_occ    <= '0;
        end else if (squash_in) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                r_head[i]  <= '0;
                r_tail[i]  <= '0;
                r_count[i] <= '0;
            end
            r_occ <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                if (w_push[i]) begin
                    r_tail[i] <= ptr_inc(r_tail[i]);
                end
                if (w_grant[i]) begin
                    r_head[i] <= ptr_inc(r_head[i]);
                end
                case ({w_push[i], w_grant[i]})
                    2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
                    2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
            r_rr_ptr <= w_rr_nxt;
            r_occ    <= r_occ + w_n_push - w_n_pop;
        end
    end

    // Payload storage carries no reset; counts alone decide what is live.
    always_ff @(posedge clock) begin : mem_q
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_tail[i]] <= fu_result_in[i];
            end
        end
    end

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Directed bench for fu_complete_arbiter: reset, latency, round-robin, back-pressure, squash and branch priority.
// Expected branch-priority lanes follow BRANCH_PRIORITY_EN when it is defined.

module tb_fu_complete_arbiter;
    import fu_complete_arbiter_pkg::*;

    logic                clock;
    logic                reset_n;
    logic                squash_in;
    fu_complete_packet_t fu_in  [6];
    logic [5:0]          fu_ready;
    fu_complete_packet_t lanes  [3];
    logic [3:0]          occ;

    int n_chk  = 0;
    int n_pass = 0;

    // Hand-derived back-pressure trace (rr_ptr=3 at start), one row per edge.
    int e_occ  [7]    = '{6, 9, 9, 9, 6, 3, 0};
    int e_rdy  [7]    = '{'h3f, 'h38, 'h07, 'h38, 'h3f, 'h3f, 'h3f};
    int e_lane [7][3] = '{'{24, 32, 40}, '{0, 8, 16}, '{25, 33, 41}, '{1, 9, 17},
                          '{26, 34, 42}, '{2, 10, 18}, '{-1, -1, -1}};

    fu_complete_arbiter #(.NUM_FU(6), .DEPTH(2), .WAYS(3)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .squash_in       (squash_in),
        .fu_result_in    (fu_in),
        .fu_ready_out    (fu_ready),
        .complete_fu_out (lanes),
        .occupancy_out   (occ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_lane(input string tag, input int w, input int exp_pr);
        if (exp_pr < 0) begin
            check($sformatf("%s_l%0d_valid", tag, w), 32'(lanes[w].valid), 32'd0);
        end else begin
            check($sformatf("%s_l%0d_valid", tag, w), 32'(lanes[w].valid), 32'd1);
            check($sformatf("%s_l%0d_pr", tag, w), 32'(lanes[w].pr_idx), 32'(exp_pr));
        end
    endtask

    function automatic fu_complete_packet_t mk(input int fu, input int seq, input logic br);
        fu_complete_packet_t p;
        p               = '0;
        p.valid         = 1'b1;
        p.pr_idx        = 6'(8 * fu + seq);
        p.rob_idx       = 5'(fu + seq);
        p.result        = 32'hA500_0000 + 32'(8 * fu + seq);
        p.take_branch   = br;
        p.branch_target = 32'h1000 + 32'(fu);
        return p;
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 6; i++) fu_in[i] = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int         p [6];
        logic [5:0] rdy_s;
        fu_complete_packet_t pkt;

        reset_n   = 1'b0;
        squash_in = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        #1;
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_rdy", 32'(fu_ready), 32'h3f);
        for (int w = 0; w < 3; w++) check_lane("rst", w, -1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Oversubscription: all six FUs push at once with rr_ptr=0.
        for (int i = 0; i < 6; i++) fu_in[i] = mk(i, 1, 1'b0);
        tick();
        clear_inputs();
        check("os1_occ", 32'(occ), 32'd6);
        check_lane("os1", 0, 1);
        check_lane("os1", 1, 9);
        check_lane("os1", 2, 17);
        tick();
        check("os2_occ", 32'(occ), 32'd3);
        check_lane("os2", 0, 25);
        check_lane("os2", 1, 33);
        check_lane("os2", 2, 41);
        tick();
        check("os3_occ", 32'(occ), 32'd0);
        check_lane("os3", 0, -1);

        // Single result from FU2, rr_ptr ends at 3.
        pkt        = mk(2, 0, 1'b0);
        pkt.pr_idx = 6'd9;
        fu_in[2]   = pkt;
        tick();
        clear_inputs();
        check("one_occ", 32'(occ), 32'd1);
        check_lane("one", 0, 9);
        check("one_res", lanes[0].result, 32'hA500_0010);
        check_lane("one", 1, -1);
        check_lane("one", 2, -1);
        tick();
        check("one_drain", 32'(occ), 32'd0);

        // Back-pressure: every FU offers 3 packets and holds each until accepted.
        for (int i = 0; i < 6; i++) p[i] = 0;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 6; i++) fu_in[i] = (p[i] < 3) ? mk(i, p[i], 1'b0) : '0;
            rdy_s = fu_ready;
            tick();
            for (int i = 0; i < 6; i++) if (fu_in[i].valid && rdy_s[i]) p[i]++;
            check($sformatf("bp%0d_occ", c), 32'(occ), 32'(e_occ[c]));
            check($sformatf("bp%0d_rdy", c), 32'(fu_ready), 32'(e_rdy[c]));
            for (int w = 0; w < 3; w++) check_lane($sformatf("bp%0d", c), w, e_lane[c][w]);
        end
        clear_inputs();
        check("bp_fu1_accepted", 32'(p[1]), 32'd3);

        // Squash with 5 buffered and FU3 pushing in the squash cycle.
        for (int i = 0; i < 6; i++) if (i != 3) fu_in[i] = mk(i, 4, 1'b0);
        tick();
        clear_inputs();
        check("sq_pre_occ", 32'(occ), 32'd5);
        check_lane("sq_pre", 0, 36);
        check_lane("sq_pre", 1, 44);
        check_lane("sq_pre", 2, 4);
        squash_in = 1'b1;
        fu_in[3]  = mk(3, 4, 1'b0);
        tick();
        squash_in = 1'b0;
        clear_inputs();
        check("sq_occ", 32'(occ), 32'd0);
        check("sq_rdy", 32'(fu_ready), 32'h3f);
        for (int w = 0; w < 3; w++) check_lane("sq", w, -1);
        tick();
        check("sq_fu3_dropped", 32'(occ), 32'd0);
        check_lane("sq_post", 0, -1);

        // Asynchronous reset mid-traffic with 4 entries buffered.
        for (int i = 0; i < 4; i++) fu_in[i] = mk(i, 6, 1'b0);
        tick();
        clear_inputs();
        check("mr_pre_occ", 32'(occ), 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_occ", 32'(occ), 32'd0);
        check("mr_rdy", 32'(fu_ready), 32'h3f);
        for (int w = 0; w < 3; w++) check_lane("mr", w, -1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Heads at FU0,1,4,5 with FU5 take_branch, rr_ptr=0 after reset.
        fu_in[0] = mk(0, 5, 1'b0);
        fu_in[1] = mk(1, 5, 1'b0);
        fu_in[4] = mk(4, 5, 1'b0);
        fu_in[5] = mk(5, 5, 1'b1);
        tick();
        clear_inputs();
        check("br_occ", 32'(occ), 32'd4);
`ifdef BRANCH_PRIORITY_EN
        check_lane("br", 0, 45);
        check_lane("br", 1, 5);
        check_lane("br", 2, 13);
        tick();
        check("br2_occ", 32'(occ), 32'd1);
        check_lane("br2", 0, 37);
`else
        check_lane("br", 0, 5);
        check_lane("br", 1, 13);
        check_lane("br", 2, 37);
        tick();
        check("br2_occ", 32'(occ), 32'd1);
        check_lane("br2", 0, 45);
`endif
        check_lane("br2", 1, -1);
        tick();
        check("br3_occ", 32'(occ), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
